sdram_port_arbiter: RTL

Shares the single SDRAM controller port (Avalon-MM-style pipelined master) between two requesters: the 720p video line fetcher, which issues fixed-length read bursts, and the frame-buffer writer, which issues single-word writes.
- Sits between the VGA pipeline and the SDRAM controller inside top.
- Video reads have priority.
- A starvation limiter guarantees the writer forward progress.

---
 rtl/sdram_port_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-way arbiter for one Avalon-MM-style SDRAM port: priority video read bursts, single-word writes.
// Optional build macro ARB_STATS_EN adds free-running grant/write/stall counters.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned WR_MAX     = 16,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic              sdr_read,
  output logic              sdr_write,
  output logic [DATA_W-1:0] sdr_wdata,
  input  logic              sdr_waitrequest,
  input  logic [DATA_W-1:0] sdr_readdata,
  input  logic              sdr_readdatavalid
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_vid_bursts,
  output logic [31:0]       stat_wr_words,
  output logic [31:0]       stat_stall
`endif
);

  localparam int unsigned BEAT_W   = $clog2(BURST_LEN + 1);
  localparam int unsigned OUT_W    = $clog2(BURST_LEN + 1);
  localparam int unsigned WCNT_W   = $clog2(WR_MAX + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VID_CMD   = 2'd1,
    VID_DRAIN = 2'd2,
    WR        = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                arb_en;
  logic [ADDR_W-1:0]   base_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [OUT_W-1:0]    outst_q;
  logic [WCNT_W-1:0]   wr_cnt_q;
  logic [STARVE_W-1:0] starve_q;

  logic base_ld, beat_clr, rd_acc, rd_ret;
  logic starve_inc, starve_clr, wr_cnt_clr;

  // Returns arriving with nothing outstanding are strays and are dropped
  assign rd_ret = sdr_readdatavalid && (outst_q != '0);

  // Holds off arbitration until the first clock after reset release
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) arb_en <= 1'b0;
    else          arb_en <= 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    vid_gnt    = 1'b0;
    sdr_read   = 1'b0;
    sdr_write  = 1'b0;
    sdr_addr   = '0;
    sdr_wdata  = '0;
    wr_ack     = 1'b0;
    base_ld    = 1'b0;
    beat_clr   = 1'b0;
    rd_acc     = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    wr_cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_en) begin
          if (vid_req && (!wr_req || (starve_q < STARVE_W'(STARVE_LIM)))) begin
            vid_gnt  = 1'b1;
            base_ld  = 1'b1;
            beat_clr = 1'b1;
            state_d  = VID_CMD;
            if (wr_req) starve_inc = 1'b1;
            else        starve_clr = 1'b1;
          end else if (wr_req) begin
            starve_clr = 1'b1;
            wr_cnt_clr = 1'b1;
            state_d    = WR;
          end
        end
      end
      VID_CMD: begin
        sdr_read = 1'b1;
        sdr_addr = base_q + ADDR_W'(beat_q);
        if (!sdr_waitrequest) begin
          rd_acc = 1'b1;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) state_d = VID_DRAIN;
        end
      end
      VID_DRAIN: begin
        if (outst_q == '0) state_d = IDLE;
      end
      WR: begin
        // Write path is combinational so the writer can drop wr_req without a trailing command
        if (wr_req && (outst_q == '0)) begin
          sdr_write = 1'b1;
          sdr_addr  = wr_addr;
          sdr_wdata = wr_data;
          wr_ack    = !sdr_waitrequest;
        end
        if (!wr_req) state_d = IDLE;
        else if (wr_ack && (wr_cnt_q == WCNT_W'(WR_MAX - 1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0;
      beat_q <= '0;
    end else begin
      if (base_ld)  base_q <= vid_addr;
      if (beat_clr) beat_q <= '0;
      else if (rd_acc) beat_q <= beat_q + BEAT_W'(1);
    end
  end

  // Accept and return in the same cycle cancel out
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      outst_q <= '0;
    end else begin
      unique case ({rd_acc, rd_ret})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (starve_clr) starve_q <= '0;
      else if (starve_inc && (starve_q != STARVE_W'(STARVE_LIM)))
        starve_q <= starve_q + STARVE_W'(1);
      if (wr_cnt_clr) wr_cnt_q <= '0;
      else if (wr_ack) wr_cnt_q <= wr_cnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      vid_rvalid <= 1'b0;
      vid_rdata  <= '0;
    end else begin
      vid_rvalid <= rd_ret;
      if (rd_ret) vid_rdata <= sdr_readdata;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      stat_vid_bursts <= '0;
      stat_wr_words   <= '0;
      stat_stall      <= '0;
    end else begin
      if (vid_gnt) stat_vid_bursts <= stat_vid_bursts + 32'd1;
      if (wr_ack)  stat_wr_words   <= stat_wr_words + 32'd1;
      if ((sdr_read || sdr_write) && sdr_waitrequest) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
